// File: rtl/fft_frame_writer_if.sv
// rtl/fft_frame_writer_if.sv - sample input, sample-RAM write port and FFT handshake of the frame writer
interface fft_frame_writer_if #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int ADDR_BITS    = 10
);
  logic                    enable_i;
  logic [SAMPLE_WIDTH-1:0] sample_i;
  logic                    sample_valid_i;
  logic [ADDR_BITS-1:0]    buf_addr_o;
  logic [SAMPLE_WIDTH-1:0] buf_data_o;
  logic                    buf_wren_o;
  logic                    buf_sel_o;
  logic                    fft_start_o;
  logic                    fft_bank_o;
  logic                    fft_end_i;
  logic                    overrun_o;
  logic                    clear_overrun_i;

  modport master (
    output enable_i, sample_i, sample_valid_i, fft_end_i, clear_overrun_i,
    input  buf_addr_o, buf_data_o, buf_wren_o, buf_sel_o, fft_start_o, fft_bank_o, overrun_o
  );

  modport slave (
    input  enable_i, sample_i, sample_valid_i, fft_end_i, clear_overrun_i,
    output buf_addr_o, buf_data_o, buf_wren_o, buf_sel_o, fft_start_o, fft_bank_o, overrun_o
  );
endinterface

// File: rtl/fft_frame_writer.sv
// rtl/fft_frame_writer.sv - collects samples into a ping-pong sample RAM and hands full banks to the FFT
module fft_frame_writer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int ADDR_BITS    = 10,
  parameter int BITREV       = 1
) (
  input logic               clk,
  input logic               rst,
  fft_frame_writer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FILL, HANDOFF, HOLD} state_t;

  state_t                  state, state_n;
  logic [ADDR_BITS-1:0]    cnt, cnt_n;
  logic [ADDR_BITS-1:0]    addr, addr_n;
  logic [SAMPLE_WIDTH-1:0] data, data_n;
  logic                    wren, wren_n;
  logic                    bank, bank_n;
  logic                    fft_bank, fft_bank_n;
  logic                    start, start_n;
  logic                    busy, busy_n;
  logic                    overrun, overrun_n;
  logic                    accept;
  logic                    drop;
  logic                    handoff;

  function automatic logic [ADDR_BITS-1:0] map_addr(input logic [ADDR_BITS-1:0] c);
    logic [ADDR_BITS-1:0] r;
    r = c;
    if (BITREV != 0) begin
      for (int i = 0; i < ADDR_BITS; i++) begin
        r[i] = c[ADDR_BITS-1-i];
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      addr     <= '0;
      data     <= '0;
      wren     <= 1'b0;
      bank     <= 1'b0;
      fft_bank <= 1'b0;
      start    <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      addr     <= addr_n;
      data     <= data_n;
      wren     <= wren_n;
      bank     <= bank_n;
      fft_bank <= fft_bank_n;
      start    <= start_n;
      busy     <= busy_n;
      overrun  <= overrun_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    addr_n     = addr;
    data_n     = data;
    wren_n     = 1'b0;
    bank_n     = bank;
    fft_bank_n = fft_bank;
    start_n    = 1'b0;
    busy_n     = busy;
    overrun_n  = overrun;
    accept     = 1'b0;
    drop       = 1'b0;
    handoff    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.enable_i) begin
          state_n = FILL;
          cnt_n   = '0;
        end
      end
      FILL: begin
        if (!bus.enable_i) begin
          state_n = IDLE;
        end else if (bus.sample_valid_i) begin
          accept = 1'b1;
          if (cnt == {ADDR_BITS{1'b1}}) begin
            state_n = HANDOFF;
          end
        end
      end
      HANDOFF: begin
        if (!bus.enable_i) begin
          state_n = IDLE;
        end else begin
          handoff = !busy || bus.fft_end_i;
          // only a successful handoff frees a bank for a sample arriving now
          if (handoff) begin
            accept = bus.sample_valid_i;
          end else begin
            state_n = HOLD;
            drop    = bus.sample_valid_i;
          end
        end
      end
      HOLD: begin
        if (!bus.enable_i) begin
          state_n = IDLE;
        end else begin
          handoff = bus.fft_end_i;
          drop    = bus.sample_valid_i;
        end
      end
      default: state_n = IDLE;
    endcase

    if (handoff) begin
      start_n    = 1'b1;
      fft_bank_n = bank;
      bank_n     = !bank;
      cnt_n      = '0;
      state_n    = FILL;
    end

    // in HANDOFF cnt has already wrapped to 0, so the same path writes sample 0
    if (accept) begin
      wren_n = 1'b1;
      addr_n = map_addr(cnt);
      data_n = bus.sample_i;
      cnt_n  = cnt + 1'b1;
    end

    if (start_n) begin
      busy_n = 1'b1;
    end else if (bus.fft_end_i) begin
      busy_n = 1'b0;
    end

    if (drop) begin
      overrun_n = 1'b1;
    end else if (bus.clear_overrun_i) begin
      overrun_n = 1'b0;
    end
  end

  assign bus.buf_addr_o  = addr;
  assign bus.buf_data_o  = data;
  assign bus.buf_wren_o  = wren;
  assign bus.buf_sel_o   = bank;
  assign bus.fft_start_o = start;
  assign bus.fft_bank_o  = fft_bank;
  assign bus.overrun_o   = overrun;
endmodule

// File: tb/tb_fft_frame_writer.sv
// tb/tb_fft_frame_writer.sv - directed bench for fft_frame_writer, natural-order and bit-reversed instances
module tb_fft_frame_writer;
  localparam int SW = 16;
  localparam int AB = 10;
  localparam int N  = 1 << AB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          valid = 1'b0;
  logic          fft_end = 1'b0;
  logic          clr = 1'b0;
  logic [SW-1:0] sample = '0;

  always #5 clk = ~clk;

  fft_frame_writer_if #(.SAMPLE_WIDTH(SW), .ADDR_BITS(AB)) bus_n ();
  fft_frame_writer_if #(.SAMPLE_WIDTH(SW), .ADDR_BITS(AB)) bus_r ();

  assign bus_n.enable_i        = enable;
  assign bus_n.sample_i        = sample;
  assign bus_n.sample_valid_i  = valid;
  assign bus_n.fft_end_i       = fft_end;
  assign bus_n.clear_overrun_i = clr;
  assign bus_r.enable_i        = enable;
  assign bus_r.sample_i        = sample;
  assign bus_r.sample_valid_i  = valid;
  assign bus_r.fft_end_i       = fft_end;
  assign bus_r.clear_overrun_i = clr;

  fft_frame_writer #(.SAMPLE_WIDTH(SW), .ADDR_BITS(AB), .BITREV(0)) dut_n (
    .clk(clk), .rst(rst), .bus(bus_n)
  );
  fft_frame_writer #(.SAMPLE_WIDTH(SW), .ADDR_BITS(AB), .BITREV(1)) dut_r (
    .clk(clk), .rst(rst), .bus(bus_r)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rev(input int x);
    int r = 0;
    for (int i = 0; i < AB; i++) begin
      r = r * 2 + ((x >> i) & 1);
    end
    return r;
  endfunction

  // Bank-ownership model: fill level of the bank being written, how long a
  // full bank has been waiting, and whether the FFT still owns the other bank.
  bit      m_active, m_owns, m_bank, m_fbank, m_ov;
  int      m_fill, m_age;
  bit      e_wren, e_start;
  int      e_idx;
  int      e_data;

  always @(posedge clk) begin
    bit win, can, drop;
    e_wren = 1'b0;
    e_start = 1'b0;
    drop = 1'b0;
    if (rst) begin
      m_active = 1'b0; m_owns = 1'b0; m_bank = 1'b0; m_fbank = 1'b0; m_ov = 1'b0;
      m_fill = 0; m_age = 0;
    end else begin
      if (!m_active) begin
        if (enable) begin
          m_active = 1'b1;
          m_fill = 0;
        end
      end else if (!enable) begin
        m_active = 1'b0;
        m_fill = 0;
      end else if (m_fill < N) begin
        if (valid) begin
          e_wren = 1'b1; e_idx = m_fill; e_data = int'(sample);
          m_fill++;
          m_age = 0;
        end
      end else begin
        win = (m_age == 0);
        can = win ? (!m_owns || fft_end) : fft_end;
        if (can) begin
          e_start = 1'b1;
          m_fbank = m_bank;
          m_bank = !m_bank;
          m_fill = 0;
          if (valid && win) begin
            e_wren = 1'b1; e_idx = 0; e_data = int'(sample);
            m_fill = 1;
          end
        end else begin
          m_age++;
        end
        drop = valid && !(can && win);
      end
      if (e_start) m_owns = 1'b1;
      else if (fft_end) m_owns = 1'b0;
      if (drop) m_ov = 1'b1;
      else if (clr) m_ov = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("wren_n", int'(bus_n.buf_wren_o), int'(e_wren));
      check("wren_r", int'(bus_r.buf_wren_o), int'(e_wren));
      if (e_wren) begin
        check("addr_n", int'(bus_n.buf_addr_o), e_idx);
        check("addr_r", int'(bus_r.buf_addr_o), rev(e_idx));
        check("data_n", int'(bus_n.buf_data_o), e_data);
        check("data_r", int'(bus_r.buf_data_o), e_data);
      end
      check("sel_n", int'(bus_n.buf_sel_o), int'(m_bank));
      check("sel_r", int'(bus_r.buf_sel_o), int'(m_bank));
      check("start_n", int'(bus_n.fft_start_o), int'(e_start));
      check("start_r", int'(bus_r.fft_start_o), int'(e_start));
      check("fbank_n", int'(bus_n.fft_bank_o), int'(m_fbank));
      check("ovr_n", int'(bus_n.overrun_o), int'(m_ov));
      check("ovr_r", int'(bus_r.overrun_o), int'(m_ov));
    end
  end

  logic          cap_wren_n, cap_start1, cap_start2, cap_fbank2, cap_sel1, cap_sel2;
  logic [AB-1:0] cap_addr_n, cap_addr_r;

  // one sample every 4 cycles; captures the write cycle and the cycle after it
  task automatic send(input logic [SW-1:0] v);
    valid = 1'b1;
    sample = v;
    @(negedge clk);
    valid = 1'b0;
    cap_wren_n = bus_n.buf_wren_o;
    cap_addr_n = bus_n.buf_addr_o;
    cap_addr_r = bus_r.buf_addr_o;
    cap_start1 = bus_n.fft_start_o;
    cap_sel1   = bus_n.buf_sel_o;
    @(negedge clk);
    cap_start2 = bus_n.fft_start_o;
    cap_fbank2 = bus_n.fft_bank_o;
    cap_sel2   = bus_n.buf_sel_o;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_wren"}, int'(bus_n.buf_wren_o | bus_r.buf_wren_o), 0);
    check({tag, "_addr"}, int'(bus_n.buf_addr_o | bus_r.buf_addr_o), 0);
    check({tag, "_data"}, int'(bus_n.buf_data_o | bus_r.buf_data_o), 0);
    check({tag, "_sel"}, int'(bus_n.buf_sel_o | bus_r.buf_sel_o), 0);
    check({tag, "_start"}, int'(bus_n.fft_start_o | bus_r.fft_start_o), 0);
    check({tag, "_fbank"}, int'(bus_n.fft_bank_o | bus_r.fft_bank_o), 0);
    check({tag, "_ovr"}, int'(bus_n.overrun_o | bus_r.overrun_o), 0);
  endtask

  int br_exp [4] = '{0, 512, 256, 768};

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    chk_on = 1'b1;
    rst = 1'b0;
    enable = 1'b1;
    repeat (2) @(negedge clk);

    // ramp frame into bank 0, FFT idle
    for (int k = 0; k < N; k++) begin
      send(SW'(k));
      if (k < 4) check("bitrev_addr", int'(cap_addr_r), br_exp[k]);
      if (k == 1) check("nat_addr1", int'(cap_addr_n), 1);
    end
    check("t1_last_wren", int'(cap_wren_n), 1);
    check("t1_last_addr", int'(cap_addr_n), 1023);
    check("t1_start_early", int'(cap_start1), 0);
    check("t1_start", int'(cap_start2), 1);
    check("t1_fbank", int'(cap_fbank2), 0);
    check("t1_sel", int'(cap_sel2), 1);

    // second frame while FFT keeps bank 0: must hold and drop
    for (int k = 0; k < N; k++) send(SW'(1024 + k));
    check("t3_no_start", int'(cap_start2), 0);
    for (int j = 0; j < 5; j++) begin
      send(SW'(16'hA000 + j));
      check("t3_drop", int'(cap_wren_n), 0);
    end
    check("t3_ovr", int'(bus_n.overrun_o), 1);
    fft_end = 1'b1;
    @(negedge clk);
    fft_end = 1'b0;
    check("t3_start", int'(bus_n.fft_start_o), 1);
    check("t3_fbank", int'(bus_n.fft_bank_o), 1);
    check("t3_sel", int'(bus_n.buf_sel_o), 0);
    check("t3_ovr_kept", int'(bus_n.overrun_o), 1);
    @(negedge clk);
    check("t3_pulse", int'(bus_n.fft_start_o), 0);
    check("t3_ovr_sticky", int'(bus_n.overrun_o), 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("t3_ovr_clr", int'(bus_n.overrun_o), 0);

    // third frame, fft_end lands in the handoff cycle
    for (int k = 0; k < N - 1; k++) send(SW'(k * 3));
    valid = 1'b1;
    sample = 16'h7777;
    @(negedge clk);
    valid = 1'b0;
    fft_end = 1'b1;
    @(negedge clk);
    fft_end = 1'b0;
    check("t4_start", int'(bus_n.fft_start_o), 1);
    check("t4_fbank", int'(bus_n.fft_bank_o), 0);
    check("t4_sel", int'(bus_n.buf_sel_o), 1);
    check("t4_ovr", int'(bus_n.overrun_o), 0);
    @(negedge clk);
    send(16'd7);
    check("t4_write", int'(cap_wren_n), 1);
    check("t4_addr", int'(cap_addr_n), 0);
    fft_end = 1'b1;
    @(negedge clk);
    fft_end = 1'b0;
    @(negedge clk);

    // partial frame abandoned by enable drop
    for (int k = 1; k < 300; k++) send(SW'(k));
    enable = 1'b0;
    send(16'd5);
    check("t5_dis_drop", int'(cap_wren_n), 0);
    check("t5_dis_ovr", int'(bus_n.overrun_o), 0);
    repeat (2) @(negedge clk);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      send(SW'(k + 200));
      if (k == 0) begin
        check("t5_addr0", int'(cap_addr_n), 0);
        check("t5_sel", int'(cap_sel1), 1);
      end
    end
    check("t5_start", int'(cap_start2), 1);
    check("t5_fbank", int'(cap_fbank2), 1);
    check("t5_sel_after", int'(cap_sel2), 0);

    // reset mid-frame while the FFT still owns bank 1
    for (int k = 0; k < 700; k++) send(SW'(k));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("midrst");
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      send(SW'(k) ^ 16'h5555);
      if (k == 0) begin
        check("t6_addr0", int'(cap_addr_n), 0);
        check("t6_sel", int'(cap_sel1), 0);
      end
    end
    check("t6_start", int'(cap_start2), 1);
    check("t6_fbank", int'(cap_fbank2), 0);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
